// File: rtl/cpu68k_bus_master.sv
// 68k-style bus initiator: one request -> setup, strobe until dtack or timeout, recover, done pulse.
// Define DTACK_SYNC_EN to pass dtack through a 2-flop synchronizer (adds 2 cycles of ack latency).
module cpu68k_bus_master #(
    parameter int SETUP_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rw,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       done,
    output logic       rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       cs,
    output logic       ds,
    output logic       rw,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    input  logic       dtack
);

    localparam int TMAX0 = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int TMAX  = (TMAX0 > RECOVERY_CYCLES) ? TMAX0 : RECOVERY_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt, timer_inc;
    logic          err, err_nxt;
    logic          cs_nxt, ds_nxt, rw_nxt, data_oe_nxt, done_nxt, rsp_err_nxt;
    logic [7:0]    data_out_nxt, rsp_rdata_nxt;
    logic          dtack_s;

`ifdef DTACK_SYNC_EN
    logic [1:0] dtack_sync;

    // Idle-high reset value so a fresh reset never looks like an acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dtack_sync <= 2'b11;
        else     dtack_sync <= {dtack_sync[0], dtack};
    end

    assign dtack_s = dtack_sync[1];
`else
    assign dtack_s = dtack;
`endif

    assign req_ready = (state == IDLE);
    assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            err       <= 1'b0;
            cs        <= 1'b0;
            ds        <= 1'b0;
            rw        <= 1'b1;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            done      <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            err       <= err_nxt;
            cs        <= cs_nxt;
            ds        <= ds_nxt;
            rw        <= rw_nxt;
            data_out  <= data_out_nxt;
            data_oe   <= data_oe_nxt;
            done      <= done_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        err_nxt       = err;
        cs_nxt        = cs;
        ds_nxt        = ds;
        rw_nxt        = rw;
        data_out_nxt  = data_out;
        data_oe_nxt   = data_oe;
        done_nxt      = 1'b0;
        rsp_err_nxt   = rsp_err;
        rsp_rdata_nxt = rsp_rdata;

        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt    = SETUP;
                    timer_nxt    = '0;
                    cs_nxt       = 1'b1;
                    rw_nxt       = req_rw;
                    data_out_nxt = req_wdata;
                    data_oe_nxt  = ~req_rw;
                end
            end
            SETUP: begin
                if (timer >= TW'(SETUP_CYCLES - 1)) begin
                    state_nxt = STROBE;
                    timer_nxt = '0;
                    ds_nxt    = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            STROBE: begin
                // An acknowledge on the timeout edge still counts as success.
                if (!dtack_s || timer >= TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = RECOVER;
                    timer_nxt   = '0;
                    ds_nxt      = 1'b0;
                    cs_nxt      = 1'b0;
                    data_oe_nxt = 1'b0;
                    rw_nxt      = 1'b1;
                    err_nxt     = dtack_s;
                    if (!dtack_s && rw) rsp_rdata_nxt = data_in;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            RECOVER: begin
                if (timer >= TW'(RECOVERY_CYCLES - 1) && dtack_s) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    rsp_err_nxt = err;
                end else if (timer >= TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    rsp_err_nxt = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu68k_bus_master.sv
// Directed bench for cpu68k_bus_master; inputs driven and outputs sampled on the falling edge.
module tb_cpu68k_bus_master;

`ifdef DTACK_SYNC_EN
    localparam int ACK_LAT = 2;
`else
    localparam int ACK_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       req_rw = 1'b0;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       done;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic       cs;
    logic       ds;
    logic       rw;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in = 8'h00;
    logic       dtack = 1'b1;

    int total = 0;
    int bad = 0;

    cpu68k_bus_master dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .done      (done),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .cs        (cs),
        .ds        (ds),
        .rw        (rw),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in),
        .dtack     (dtack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    // Waits for the done pulse; n = ticks until seen, -1 if the budget expires.
    task automatic wait_done(input int limit, output int n, output bit oe_seen);
        n = -1;
        oe_seen = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (data_oe) oe_seen = 1'b1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    // Write with a one-cycle dtack pulse two cycles after ds rises.
    task automatic run_write(input logic [7:0] wd, output int n);
        bit oe;
        req = 1'b1; req_rw = 1'b0; req_wdata = wd;
        tick(); req = 1'b0;
        tick();
        tick(); dtack = 1'b0;
        tick(); dtack = 1'b1;
        wait_done(40, n, oe);
    endtask

    task automatic test_reset;
        tick();
        total++;
        if (cs !== 1'b0 || ds !== 1'b0 || rw !== 1'b1 || data_oe !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_bus: cs=%b ds=%b rw=%b oe=%b dout=%h want 0 0 1 0 00", cs, ds, rw, data_oe, data_out);
        end
        total++;
        if (done !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_rsp: done=%b err=%b rdata=%h ready=%b want 0 0 00 1", done, rsp_err, rsp_rdata, req_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write;
        int n;
        bit oe;
        req = 1'b1; req_rw = 1'b0; req_wdata = 8'hA5;
        tick(); req = 1'b0;
        total++;
        if (cs !== 1'b1 || rw !== 1'b0 || data_oe !== 1'b1 || data_out !== 8'hA5 || ds !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL write_setup: cs=%b rw=%b oe=%b dout=%h ds=%b ready=%b want 1 0 1 a5 0 0", cs, rw, data_oe, data_out, ds, req_ready);
        end
        tick();
        total++;
        if (ds !== 1'b1 || cs !== 1'b1 || rw !== 1'b0 || data_oe !== 1'b1 || data_out !== 8'hA5) begin
            bad++;
            $display("FAIL write_strobe1: ds=%b cs=%b rw=%b oe=%b dout=%h want 1 1 0 1 a5", ds, cs, rw, data_oe, data_out);
        end
        tick();
        total++;
        if (ds !== 1'b1 || cs !== 1'b1 || data_oe !== 1'b1 || data_out !== 8'hA5) begin
            bad++;
            $display("FAIL write_strobe2: ds=%b cs=%b oe=%b dout=%h want 1 1 1 a5", ds, cs, data_oe, data_out);
        end
        dtack = 1'b0;
        tick(); dtack = 1'b1;
        wait_done(40, n, oe);
        total++;
        if (n !== 1 + ACK_LAT) begin
            bad++;
            $display("FAIL write_done_latency: got %0d want %0d", n, 1 + ACK_LAT);
        end
        total++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 8'h00 || cs !== 1'b0 || data_oe !== 1'b0) begin
            bad++;
            $display("FAIL write_rsp: err=%b rdata=%h cs=%b oe=%b want 0 00 0 0", rsp_err, rsp_rdata, cs, data_oe);
        end
        tick();
        total++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_pulse: done=%b ready=%b want 0 1", done, req_ready);
        end
    endtask

    task automatic test_read;
        int n;
        bit oe;
        bit oe_any;
        req = 1'b1; req_rw = 1'b1; req_wdata = 8'hFF;
        tick(); req = 1'b0;
        oe_any = data_oe;
        total++;
        if (cs !== 1'b1 || rw !== 1'b1) begin
            bad++;
            $display("FAIL read_setup: cs=%b rw=%b want 1 1", cs, rw);
        end
        tick(); oe_any |= data_oe;
        tick(); oe_any |= data_oe;
        data_in = 8'h3C; dtack = 1'b0;
        tick(); oe_any |= data_oe;
        dtack = 1'b1;
        wait_done(40, n, oe);
        oe_any |= oe;
        data_in = 8'h00;
        total++;
        if (n !== 1 + ACK_LAT || rsp_err !== 1'b0 || rsp_rdata !== 8'h3C) begin
            bad++;
            $display("FAIL read_done: lat=%0d err=%b rdata=%h want %0d 0 3c", n, rsp_err, rsp_rdata, 1 + ACK_LAT);
        end
        total++;
        if (oe_any !== 1'b0) begin
            bad++;
            $display("FAIL read_oe: got %b want 0", oe_any);
        end
        run_write(8'h77, n);
        total++;
        if (n !== 1 + ACK_LAT || rsp_rdata !== 8'h3C) begin
            bad++;
            $display("FAIL read_hold: lat=%0d rdata=%h want %0d 3c", n, rsp_rdata, 1 + ACK_LAT);
        end
    endtask

    task automatic test_timeout;
        int n;
        req = 1'b1; req_rw = 1'b0; req_wdata = 8'h11;
        tick(); req = 1'b0;
        tick();
        total++;
        if (ds !== 1'b1) begin
            bad++;
            $display("FAIL timeout_ds_rise: got %b want 1", ds);
        end
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!ds) begin
                n = i;
                break;
            end
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL timeout_ds_width: got %0d want 16", n);
        end
        tick();
        total++;
        if (done !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h3C) begin
            bad++;
            $display("FAIL timeout_rsp: done=%b err=%b rdata=%h want 1 1 3c", done, rsp_err, rsp_rdata);
        end
        tick();
        total++;
        if (done !== 1'b0 || rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err_hold: done=%b err=%b want 0 1", done, rsp_err);
        end
    endtask

    task automatic test_back_to_back;
        int  dones = 0;
        int  gap = 0;
        bit  started = 1'b0;
        bit  acked = 1'b0;
        req = 1'b1; req_rw = 1'b1;
        for (int i = 0; i < 300 && dones < 3; i++) begin
            tick();
            if (cs) begin
                if (started && gap > 0) begin
                    total++;
                    if (gap < 2) begin
                        bad++;
                        $display("FAIL b2b_gap: got %0d want >=2", gap);
                    end
                end
                gap = 0;
                started = 1'b1;
                total++;
                if (req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_ready_busy: got %b want 0", req_ready);
                end
            end else if (started) begin
                gap++;
            end
            if (done) begin
                total++;
                if (rsp_rdata !== 8'h41 + 8'(dones) || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_done: rdata=%h err=%b ready=%b want %h 0 1", rsp_rdata, rsp_err, req_ready, 8'h41 + 8'(dones));
                end
                dones++;
                if (dones == 3) req = 1'b0;
            end
            if (!ds) acked = 1'b0;
            if (!dtack) begin
                dtack = 1'b1;
            end else if (ds && !acked) begin
                dtack = 1'b0;
                data_in = 8'h41 + 8'(dones);
                acked = 1'b1;
            end
        end
        dtack = 1'b1;
        total++;
        if (dones !== 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 3", dones);
        end
        tick(); tick(); tick();
        total++;
        if (cs !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_stop: cs=%b ready=%b want 0 1", cs, req_ready);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit spurious = 1'b0;
        req = 1'b1; req_rw = 1'b0; req_wdata = 8'hC3;
        tick(); req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (cs !== 1'b0 || ds !== 1'b0 || data_oe !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_bus: cs=%b ds=%b oe=%b want 0 0 0", cs, ds, data_oe);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) spurious = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) spurious = 1'b1;
        end
        total++;
        if (spurious !== 1'b0 || rsp_rdata !== 8'h00 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_quiet: done_seen=%b rdata=%h ready=%b want 0 00 1", spurious, rsp_rdata, req_ready);
        end
        run_write(8'h5A, n);
        total++;
        if (n !== 1 + ACK_LAT || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_recover: lat=%0d err=%b want %0d 0", n, rsp_err, 1 + ACK_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
